unsigned_seq_divider_16by8: RTL and testbench

//  Sequential restoring divider, the inverse of the 8x8 unsigned multipliers: given product z (2W bits) and

---
 rtl/div_pkg.sv | 15 +
 rtl/unsigned_seq_divider_16by8_if.sv | 29 ++
 rtl/unsigned_seq_divider_16by8_step.sv | 25 ++
 rtl/unsigned_seq_divider_16by8.sv | 133 +++++++++++++
 tb/tb_unsigned_seq_divider_16by8.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int W_DEF = 8;

    // Result pattern for flagged ops; slice to the operand width at the point of use.
    localparam logic [31:0] ALL_ONES = '1;

endpackage

// File: rtl/unsigned_seq_divider_16by8_if.sv
// Request/response handshake bundle between the divider and its producer/consumer.
interface unsigned_seq_divider_16by8_if
    import div_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] z;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           div0;
    logic           ovf;

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, q, r, div0, ovf
    );

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, q, r, div0, ovf
    );

endinterface

// File: rtl/unsigned_seq_divider_16by8_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and trial-subtract y.
module div_restore_step
    import div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] rem_o,
    output logic         qbit_o
);

    logic [W:0] partial;
    logic [W:0] trial;
    logic       borrow;

    assign partial         = {rem_i, bit_i};
    assign {borrow, trial} = {1'b0, partial} - {2'b00, y_i};

    // rem_i < y_i keeps partial < 2*y_i, so a successful trial always fits in W bits.
    assign qbit_o = ~borrow;
    assign rem_o  = borrow ? partial[W-1:0] : W'(trial);

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Sequential 2W-by-W unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
module unsigned_seq_divider_16by8
    import div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    unsigned_seq_divider_16by8_if.slave bus
);

    localparam int               CNT_W    = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [W-1:0]     FLAG_RES = ALL_ONES[W-1:0];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     y_q, y_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     r_q, r_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     step_rem;
    logic             step_qbit;
    logic             is_div0;
    logic             is_ovf;
    logic             last_cnt;
    logic             in_ready;
    logic             out_valid;

    assign is_div0  = (bus.y == '0);
    assign is_ovf   = (bus.z[2*W-1:W] >= bus.y);
    assign last_cnt = (cnt_q == CNT_LAST);

    div_restore_step #(.W(W)) u_step (
        .rem_i  (rem_q),
        .bit_i  (lo_q[W-1]),
        .y_i    (y_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid) state_d = (is_div0 || is_ovf) ? S_DONE : S_RUN;
            S_RUN:  if (last_cnt) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // lo doubles as the quotient register: dividend bits leave at the top as quotient bits enter at the bottom.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        lo_d   = lo_q;
        y_d    = y_q;
        q_d    = q_q;
        r_d    = r_q;
        div0_d = div0_q;
        ovf_d  = ovf_q;
        unique case (state_q)
            S_IDLE: if (bus.in_valid) begin
                y_d   = bus.y;
                rem_d = bus.z[2*W-1:W];
                lo_d  = bus.z[W-1:0];
                cnt_d = '0;
                if (is_div0 || is_ovf) begin
                    div0_d = is_div0;
                    ovf_d  = ~is_div0;
                    q_d    = FLAG_RES;
                    r_d    = FLAG_RES;
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                lo_d  = {lo_q[W-2:0], step_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_cnt) begin
                    q_d    = {lo_q[W-2:0], step_qbit};
                    r_d    = step_rem;
                    div0_d = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            r_q    <= r_d;
            div0_q <= div0_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        lo_q  <= lo_d;
        y_q   <= y_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.q         = q_q;
    assign bus.r         = r_q;
    assign bus.div0      = div0_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Bench for the sequential divider: directed vector table, handshake/reset corner sequences, random ops vs. arithmetic model.
module tb_unsigned_seq_divider_16by8;

    localparam int W = 8;
    localparam int TMO = 50;

    typedef struct {
        logic [15:0] z;
        logic [7:0]  y;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        d0;
        logic        ov;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    unsigned_seq_divider_16by8_if #(.W(W)) bus ();

    unsigned_seq_divider_16by8 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: plain integer division, with the flag rules for zero divisor and quotient overflow.
    task automatic model(input logic [15:0] z, input logic [7:0] y,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic d0, output logic ov, output int lat);
        int zi, yi;
        zi = int'(z);
        yi = int'(y);
        if (yi == 0) begin
            q = 8'hFF; r = 8'hFF; d0 = 1'b1; ov = 1'b0; lat = 0;
        end else if (zi / yi > 255) begin
            q = 8'hFF; r = 8'hFF; d0 = 1'b0; ov = 1'b1; lat = 0;
        end else begin
            q = 8'(zi / yi); r = 8'(zi % yi); d0 = 1'b0; ov = 1'b0; lat = W;
        end
    endtask

    // lat = clock edges after the accept edge until out_valid is seen.
    task automatic run_op(input logic [15:0] z, input logic [7:0] y,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic d0, output logic ov, output int lat, output bit ok);
        int t;
        ok = 1'b0;
        q = '0; r = '0; d0 = 1'b0; ov = 1'b0; lat = -1;
        t = 0;
        while (!bus.in_ready && t < TMO) begin
            @(posedge clk); #1; t++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.z = z;
        bus.y = y;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < TMO) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
            return;
        end
        q = bus.q; r = bus.r; d0 = bus.div0; ov = bus.ovf;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        ok = 1'b1;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [7:0]  q, r, eq, er;
        logic        d0, ov, ed0, eov;
        int          lat, elat;
        bit          ok;

        vecs[0] = '{16'd15000, 8'd125, 8'd120, 8'd0,   1'b0, 1'b0, 8};
        vecs[1] = '{16'hFE01,  8'd255, 8'd255, 8'd0,   1'b0, 1'b0, 8};
        vecs[2] = '{16'd1000,  8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 8};
        vecs[3] = '{16'h1234,  8'd0,   8'hFF,  8'hFF,  1'b1, 1'b0, 0};
        vecs[4] = '{16'h0500,  8'd5,   8'hFF,  8'hFF,  1'b0, 1'b1, 0};
        vecs[5] = '{16'h04FF,  8'd5,   8'd255, 8'd4,   1'b0, 1'b0, 8};
        vecs[6] = '{16'h0000,  8'd1,   8'd0,   8'd0,   1'b0, 1'b0, 8};
        vecs[7] = '{16'h00FF,  8'd255, 8'd1,   8'd0,   1'b0, 1'b0, 8};
        vecs[8] = '{16'hFFFF,  8'd0,   8'hFF,  8'hFF,  1'b1, 1'b0, 0};
        vecs[9] = '{16'hFFFF,  8'd255, 8'hFF,  8'hFF,  1'b0, 1'b1, 0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.z         = '0;
        bus.y         = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_q",         32'(bus.q),         32'd0);
        check("rst_r",         32'(bus.r),         32'd0);
        check("rst_div0",      32'(bus.div0),      32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].z, vecs[i].y, q, r, d0, ov, lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_q", i),    32'(q),  32'(vecs[i].q));
                check($sformatf("vec%0d_r", i),    32'(r),  32'(vecs[i].r));
                check($sformatf("vec%0d_div0", i), 32'(d0), 32'(vecs[i].d0));
                check($sformatf("vec%0d_ovf", i),  32'(ov), 32'(vecs[i].ov));
                check($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            end
        end

        // Consumer stalls in DONE while a new request is offered.
        bus.z = 16'd1000; bus.y = 8'd7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < TMO) begin
            @(posedge clk); #1; lat++;
        end
        check("stall_reach_done", 32'(bus.out_valid), 32'd1);
        bus.z = 16'h0010; bus.y = 8'd3; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_q",         32'(bus.q),         32'd142);
            check("stall_r",         32'(bus.r),         32'd6);
            check("stall_flags",     {30'd0, bus.div0, bus.ovf}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("pop_out_valid", 32'(bus.out_valid), 32'd0);
        check("pop_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        check("pop_no_accept", 32'(bus.in_ready), 32'd1);

        // Reset lands in the middle of a division.
        bus.z = 16'd15000; bus.y = 8'd125; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrun_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrun_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrun_rst_q",         32'(bus.q),         32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("midrun_no_result", 32'(bus.out_valid), 32'd0);

        // Exact products must come back with zero remainder.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0]  x, yy;
            logic [15:0] z;
            x  = 8'($urandom_range(0, 255));
            yy = 8'($urandom_range(1, 255));
            z  = 16'(int'(x) * int'(yy));
            run_op(z, yy, q, r, d0, ov, lat, ok);
            if (ok) begin
                check("prod_q",     32'(q), 32'(x));
                check("prod_r",     32'(r), 32'd0);
                check("prod_flags", {30'd0, d0, ov}, 32'd0);
                check("prod_lat",   32'(lat), 32'(W));
            end
        end

        // Arbitrary dividends, biased toward the non-overflow region half the time.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] z;
            logic [7:0]  yy;
            yy = 8'($urandom_range(0, 255));
            if (i % 2 == 0 && yy != 0) z = 16'($urandom_range(0, int'(yy) * 256 - 1));
            else                       z = 16'($urandom);
            model(z, yy, eq, er, ed0, eov, elat);
            run_op(z, yy, q, r, d0, ov, lat, ok);
            if (ok) begin
                check("rnd_q",    32'(q),   32'(eq));
                check("rnd_r",    32'(r),   32'(er));
                check("rnd_div0", 32'(d0),  32'(ed0));
                check("rnd_ovf",  32'(ov),  32'(eov));
                check("rnd_lat",  32'(lat), 32'(elat));
                if (!ed0 && !eov)
                    check("rnd_identity", 32'(int'(q) * int'(yy) + int'(r)), 32'(z));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
